// File: rtl/if_fetch_unit_if.sv
// Program-memory read port of the fetch stage: registered req/addr from the fetch
// unit, ack/rdata returned by the memory in the cycle it accepts the request.
interface if_fetch_unit_if #(
   parameter int ADDR_WIDTH = 32
) ();
   logic                  imem_req;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic                  imem_ack;
   logic [31:0]           imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one outstanding program-memory
// read at a time and buffers returned words in a prefetch FIFO for the IF/ID register.
module if_fetch_unit #(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    FIFO_DEPTH = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  branch_valid,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   if_fetch_unit_if.master       imem,
   output logic [31:0]           instruction_out,
   output logic [ADDR_WIDTH-1:0] pc_out,
   output logic                  take_branch_addr_out,
   output logic                  fetch_valid
);

   localparam int                    PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int                    CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);
   localparam logic [PTR_W-1:0]      PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);

   // fetch_pc_q is the next address to issue; addr_q holds the address on the bus
   logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
   logic                  req_q,      req_d;
   logic                  drop_q,     drop_d;
   logic                  redir_q,    redir_d;
   logic [PTR_W-1:0]      rd_ptr_q,   rd_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q,   wr_ptr_d;
   logic [CNT_W-1:0]      count_q,    count_d;
   logic [31:0]           mem_data_q [FIFO_DEPTH];
   logic [31:0]           mem_data_d [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] mem_pc_q   [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] mem_pc_d   [FIFO_DEPTH];
   logic                  mem_flag_q [FIFO_DEPTH];
   logic                  mem_flag_d [FIFO_DEPTH];

   logic                  xfer_s;
   logic                  pend_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  fifo_valid_s;
   logic [ADDR_WIDTH-1:0] tgt_s;
   logic [ADDR_WIDTH-1:0] base_s;
   logic                  unused_tgt_s;

   assign xfer_s       = req_q & imem.imem_ack;
   assign pend_s       = req_q & ~imem.imem_ack;
   assign fifo_valid_s = (count_q != '0);
   assign push_s       = xfer_s & ~drop_q & ~branch_valid;
   assign pop_s        = fifo_valid_s & ~stall & ~branch_valid;
   assign tgt_s        = {branch_target[ADDR_WIDTH-1:2], 2'b00};
   assign base_s       = branch_valid ? tgt_s : fetch_pc_q;
   assign unused_tgt_s = ^branch_target[1:0];

   // Prefetch FIFO: flush on redirect, otherwise push/pop independently
   always_comb begin
      mem_data_d = mem_data_q;
      mem_pc_d   = mem_pc_q;
      mem_flag_d = mem_flag_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      if (branch_valid) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_s) begin
            mem_data_d[wr_ptr_q] = imem.imem_rdata;
            mem_pc_d[wr_ptr_q]   = addr_q;
            mem_flag_d[wr_ptr_q] = redir_q;
            wr_ptr_d             = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // Request issue: hold an unacked request, else issue while the FIFO has room
   always_comb begin
      fetch_pc_d = base_s;
      addr_d     = addr_q;
      req_d      = 1'b0;
      if (pend_s) begin
         req_d = 1'b1;
      end else if (count_d < DEPTH_C) begin
         req_d      = 1'b1;
         addr_d     = base_s;
         fetch_pc_d = base_s + PC_STEP;
      end else begin
         req_d = 1'b0;
      end
   end

   // Drop marks a pre-redirect request still in flight; redirect tags the first kept word
   always_comb begin
      drop_d  = drop_q;
      redir_d = redir_q;
      if (xfer_s) begin
         drop_d = 1'b0;
      end else if (branch_valid && pend_s) begin
         drop_d = 1'b1;
      end else begin
         drop_d = drop_q;
      end
      if (branch_valid) begin
         redir_d = 1'b1;
      end else if (push_s) begin
         redir_d = 1'b0;
      end else begin
         redir_d = redir_q;
      end
   end

   // State registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         addr_q     <= RESET_PC;
         req_q      <= 1'b0;
         drop_q     <= 1'b0;
         redir_q    <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_data_q[i] <= 32'h0000_0000;
            mem_pc_q[i]   <= '0;
            mem_flag_q[i] <= 1'b0;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
         req_q      <= req_d;
         drop_q     <= drop_d;
         redir_q    <= redir_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         mem_data_q <= mem_data_d;
         mem_pc_q   <= mem_pc_d;
         mem_flag_q <= mem_flag_d;
      end
   end

   assign imem.imem_req        = req_q;
   assign imem.imem_addr       = addr_q;
   assign fetch_valid          = fifo_valid_s;
   assign instruction_out      = fifo_valid_s ? mem_data_q[rd_ptr_q] : 32'h0000_0000;
   assign pc_out               = fifo_valid_s ? mem_pc_q[rd_ptr_q] : '0;
   assign take_branch_addr_out = fifo_valid_s ? mem_flag_q[rd_ptr_q] : 1'b0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus random stall/branch/ack traffic,
// checked every cycle against a queue-based model of the fetch stage.
module tb_if_fetch_unit;

   logic        clock;
   logic        reset;
   logic        stall;
   logic        branch_valid;
   logic [31:0] branch_target;
   logic [31:0] instruction_out;
   logic [31:0] pc_out;
   logic        take_branch_addr_out;
   logic        fetch_valid;

   int total_cnt = 0;
   int bad_cnt   = 0;

   if_fetch_unit_if #(.ADDR_WIDTH(32)) imem_bus ();

   if_fetch_unit #(
      .ADDR_WIDTH (32),
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .clock                (clock),
      .reset                (reset),
      .stall                (stall),
      .branch_valid         (branch_valid),
      .branch_target        (branch_target),
      .imem                 (imem_bus),
      .instruction_out      (instruction_out),
      .pc_out               (pc_out),
      .take_branch_addr_out (take_branch_addr_out),
      .fetch_valid          (fetch_valid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: words in flight to the decoder as a queue, plus the bus view
   typedef struct {
      logic [31:0] data;
      logic [31:0] pc;
      logic        flag;
   } entry_t;

   localparam int DEPTH = 2;

   entry_t      m_q [$];
   logic        m_req;
   logic [31:0] m_addr;
   logic [31:0] m_next_pc;
   logic        m_drop;
   logic        m_redir;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      if (obs !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_req     = 1'b0;
      m_addr    = 32'h0000_0000;
      m_next_pc = 32'h0000_0000;
      m_drop    = 1'b0;
      m_redir   = 1'b0;
   endtask

   // One clock edge of the fetch stage as described behaviourally
   task automatic model_edge(input logic s, input logic b, input logic [31:0] t,
                             input logic a, input logic [31:0] rd);
      logic   acked;
      logic   still_waiting;
      entry_t e;
      acked         = m_req && a;
      still_waiting = m_req && !a;
      if (b) begin
         m_q.delete();
         m_next_pc = {t[31:2], 2'b00};
         m_redir   = 1'b1;
         m_drop    = still_waiting;
      end else begin
         if (m_q.size() != 0 && !s) void'(m_q.pop_front());
         if (acked && !m_drop) begin
            e.data  = rd;
            e.pc    = m_addr;
            e.flag  = m_redir;
            m_q.push_back(e);
            m_redir = 1'b0;
         end
         if (acked) m_drop = 1'b0;
      end
      if (!still_waiting) begin
         if (m_q.size() < DEPTH) begin
            m_req     = 1'b1;
            m_addr    = m_next_pc;
            m_next_pc = m_next_pc + 32'd4;
         end else begin
            m_req = 1'b0;
         end
      end
   endtask

   task automatic check_outputs();
      chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, (m_q.size() != 0)});
      if (m_q.size() != 0) begin
         chk("instruction_out", instruction_out, m_q[0].data);
         chk("pc_out", pc_out, m_q[0].pc);
         chk("take_branch", {31'd0, take_branch_addr_out}, {31'd0, m_q[0].flag});
      end else begin
         chk("nop_instr", instruction_out, 32'h0000_0000);
         chk("nop_pc", pc_out, 32'h0000_0000);
         chk("nop_take_branch", {31'd0, take_branch_addr_out}, 32'd0);
      end
      chk("imem_req", {31'd0, imem_bus.imem_req}, {31'd0, m_req});
      if (m_req) chk("imem_addr", imem_bus.imem_addr, m_addr);
   endtask

   // Called at a negedge: check, drive inputs, clock, advance model, return at negedge
   task automatic step(input logic s, input logic b, input logic [31:0] t, input logic a);
      logic [31:0] rd;
      check_outputs();
      rd                  = $urandom;
      stall               = s;
      branch_valid        = b;
      branch_target       = t;
      imem_bus.imem_ack   = a;
      imem_bus.imem_rdata = rd;
      @(posedge clock);
      model_edge(s, b, t, a, rd);
      @(negedge clock);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [31:0] tgt;
      reset               = 1'b1;
      stall               = 1'b0;
      branch_valid        = 1'b0;
      branch_target       = 32'h0000_0000;
      imem_bus.imem_ack   = 1'b0;
      imem_bus.imem_rdata = 32'h0000_0000;
      #1;
      chk("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
      chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
      chk("rst_instr", instruction_out, 32'h0000_0000);
      apply_reset();

      // zero-wait-state streaming
      repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

      // stall fills the FIFO then releases
      apply_reset();
      repeat (5) step(1'b1, 1'b0, 32'h0, 1'b1);
      repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1);

      // wait-state memory with a redirect while a request is pending
      step(1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b1, 32'h0000_0100, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

      // redirect coinciding with ack, unaligned target
      step(1'b0, 1'b1, 32'h0000_0203, 1'b1);
      repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

      // address wrap at the top of memory
      step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
      repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

      // async reset with one buffered word and a request pending
      apply_reset();
      step(1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      check_outputs();
      #2;
      reset = 1'b1;
      #1;
      chk("async_req", {31'd0, imem_bus.imem_req}, 32'd0);
      chk("async_valid", {31'd0, fetch_valid}, 32'd0);
      chk("async_instr", instruction_out, 32'h0000_0000);
      chk("async_pc", pc_out, 32'h0000_0000);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      stall = 1'b0;
      repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         tgt = $urandom;
         if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'h0000_000F);
         step(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0), tgt,
              ($urandom_range(0, 9) < 6));
      end
      check_outputs();

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
